// File: rtl/in_layer_loader.sv
`default_nettype none
// ============================================================================
//  Module      : in_layer_loader
//  Description : Serial-to-parallel front end of the neural min-sum decoder.
//                Collects N_V channel LLRs from a valid/ready stream, then
//                presents them in parallel as per-variable LLRs and as the
//                initial per-edge messages routed through the Tanner-graph
//                adjacency matrix, with a frame-level valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module in_layer_loader #(
  parameter int N_V  = 44,
  parameter int N_C  = 12,
  parameter int E    = 147,
  parameter int N_FP = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [0:N_V-1][0:E-1]        adj_matrix,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [N_FP-1:0]       s_llr,
  input  logic                         s_last,
  output logic signed [N_FP-1:0]       llr_out  [0:N_V-1],
  output logic signed [N_FP-1:0]       edge_msg [0:E-1],
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         frame_err
);

  localparam int              c_idx_w    = (N_V > 1) ? $clog2(N_V) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_V - 1);

  localparam logic [1:0] c_st_load = 2'd0;
  localparam logic [1:0] c_st_map  = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [c_idx_w-1:0]       r_idx;
  logic [c_idx_w-1:0]       w_idx_nxt;
  logic signed [N_FP-1:0]   r_buf  [0:N_V-1];
  logic signed [N_FP-1:0]   r_llr  [0:N_V-1];
  logic signed [N_FP-1:0]   r_edge [0:E-1];
  logic signed [N_FP-1:0]   w_edge_sel [0:E-1];
  logic                     r_s_ready;
  logic                     r_m_valid;
  logic                     r_frame_err;
  logic                     w_s_ready_nxt;
  logic                     w_m_valid_nxt;
  logic                     w_frame_err_nxt;
  logic                     w_beat;
  logic                     w_at_last;

  assign w_beat    = s_valid & r_s_ready;
  assign w_at_last = (r_idx == c_last_idx);

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign frame_err = r_frame_err;
  assign llr_out   = r_llr;
  assign edge_msg  = r_edge;

  // State, word index and registered handshake/status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_st_load;
      r_idx       <= '0;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state and word-index logic; a frame ends on the N_V-th beat or an early s_last
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      c_st_load: begin
        if (w_beat) begin
          if (w_at_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = c_st_map;
          end else if (s_last) begin
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      c_st_map:  w_state_nxt = c_st_hold;
      c_st_hold: begin
        if (r_m_valid && m_ready) begin
          w_state_nxt = c_st_load;
        end
      end
      default:   w_state_nxt = c_st_load;
    endcase
  end

  // Output flags: m_valid rises on the second HOLD-side cycle and drops on the handshake
  always_comb begin
    w_s_ready_nxt   = (w_state_nxt == c_st_load);
    w_m_valid_nxt   = (r_state == c_st_hold) && !(r_m_valid && m_ready);
    w_frame_err_nxt = (r_state == c_st_load) && w_beat &&
                      ((!w_at_last && s_last) || (w_at_last && !s_last));
  end

  // Each edge takes the LLR of the lowest-indexed variable attached to it
  always_comb begin
    for (int e = 0; e < E; e++) begin
      w_edge_sel[e] = '0;
      for (int v = N_V - 1; v >= 0; v--) begin
        if (adj_matrix[v][e]) begin
          w_edge_sel[e] = r_buf[v];
        end
      end
    end
  end

  // Codeword buffer: one word captured per accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < N_V; v++) begin
        r_buf[v] <= '0;
      end
    end else if ((r_state == c_st_load) && w_beat) begin
      r_buf[r_idx] <= s_llr;
    end
  end

  // Parallel outputs load once in MAP and are held until the next frame maps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < N_V; v++) begin
        r_llr[v] <= '0;
      end
      for (int e = 0; e < E; e++) begin
        r_edge[e] <= '0;
      end
    end else if (r_state == c_st_map) begin
      for (int v = 0; v < N_V; v++) begin
        r_llr[v] <= r_buf[v];
      end
      for (int e = 0; e < E; e++) begin
        r_edge[e] <= w_edge_sel[e];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_in_layer_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_in_layer_loader
//  Description : Self-checking bench for in_layer_loader. Expected frames are
//                queued as stimulus is driven; a monitor pops and compares
//                them on every cycle the DUT presents a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_in_layer_loader;

  localparam int NV = 44;
  localparam int NC = 12;
  localparam int NE = 147;
  localparam int FP = 8;

  typedef logic [0:NV-1][FP-1:0] llr_vec_t;
  typedef logic [0:NE-1][FP-1:0] edge_vec_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [0:NV-1][0:NE-1] adj = '0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic signed [FP-1:0]  s_llr = '0;
  logic                  s_last = 1'b0;
  logic signed [FP-1:0]  llr_out  [0:NV-1];
  logic signed [FP-1:0]  edge_msg [0:NE-1];
  logic                  m_valid;
  logic                  m_ready = 1'b0;
  logic                  frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int frames_seen = 0;
  int err_pulses = 0;

  logic signed [FP-1:0] vals [0:NV-1];
  llr_vec_t  q_llr [$];
  edge_vec_t q_edge [$];
  llr_vec_t  cur_llr;
  edge_vec_t cur_edge;
  bit        mon_active = 1'b0;
  int        mon_d, mon_idx;

  in_layer_loader #(.N_V(NV), .N_C(NC), .E(NE), .N_FP(FP)) dut (
    .clk        (clk),
    .rst        (rst),
    .adj_matrix (adj),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_llr      (s_llr),
    .s_last     (s_last),
    .llr_out    (llr_out),
    .edge_msg   (edge_msg),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: checks every cycle a frame is presented, including held cycles
  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (!rst) begin
      mon_active = 1'b0;
    end else if (m_valid) begin
      if (!mon_active) begin
        if (q_llr.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL sb_unexpected_frame: m_valid=1 but no frame expected");
        end else begin
          cur_llr  = q_llr.pop_front();
          cur_edge = q_edge.pop_front();
          mon_active = 1'b1;
          frames_seen++;
        end
      end
      if (mon_active) begin
        mon_d = 0; mon_idx = -1;
        for (int i = 0; i < NV; i++)
          if (llr_out[i] !== cur_llr[i]) begin mon_d++; if (mon_idx < 0) mon_idx = i; end
        n_cmp++;
        if (mon_d != 0) begin
          n_err++;
          $display("FAIL sb_llr_out frame %0d: %0d bad, llr_out[%0d]=%0d required %0d",
                   frames_seen, mon_d, mon_idx, llr_out[mon_idx], $signed(cur_llr[mon_idx]));
        end
        mon_d = 0; mon_idx = -1;
        for (int i = 0; i < NE; i++)
          if (edge_msg[i] !== cur_edge[i]) begin mon_d++; if (mon_idx < 0) mon_idx = i; end
        n_cmp++;
        if (mon_d != 0) begin
          n_err++;
          $display("FAIL sb_edge_msg frame %0d: %0d bad, edge_msg[%0d]=%0d required %0d",
                   frames_seen, mon_d, mon_idx, edge_msg[mon_idx], $signed(cur_edge[mon_idx]));
        end
        if (m_ready) mon_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_adj_mod();
    for (int v = 0; v < NV; v++)
      for (int e = 0; e < NE; e++)
        adj[v][e] = ((e % NV) == v);
  endtask

  // Reference model: edge takes value of the first attached variable scanning upward
  task automatic push_expected();
    llr_vec_t  l;
    edge_vec_t ev;
    bit found;
    for (int v = 0; v < NV; v++) l[v] = vals[v];
    for (int e = 0; e < NE; e++) begin
      ev[e] = '0;
      found = 1'b0;
      for (int v = 0; v < NV; v++)
        if (!found && adj[v][e]) begin ev[e] = vals[v]; found = 1'b1; end
    end
    q_llr.push_back(l);
    q_edge.push_back(ev);
  endtask

  task automatic send_frame(input int n_words, input int last_at, input bit throttle);
    int budget;
    bit acc;
    for (int w = 0; w < n_words; w++) begin
      budget = 0; acc = 1'b0;
      s_valid = 1'b1; s_llr = vals[w]; s_last = (w == last_at);
      while (!acc) begin
        acc = s_ready;
        tick();
        budget++;
        if (!acc && budget > 50) begin
          n_cmp++; n_err++;
          $display("FAIL send_timeout: word %0d not accepted, s_ready=%0b required 1", w, s_ready);
          s_valid = 1'b0; s_last = 1'b0;
          return;
        end
      end
      s_valid = 1'b0; s_last = 1'b0;
      if (throttle && w != n_words - 1) tick();
    end
  endtask

  task automatic wait_frames(input int target);
    int i;
    for (i = 0; i < 200; i++) begin
      if (frames_seen >= target && !m_valid && q_llr.size() == 0) break;
      tick();
    end
    n_cmp++;
    if (i >= 200) begin
      n_err++;
      $display("FAIL frame_timeout: frames_seen=%0d required %0d", frames_seen, target);
    end
  endtask

  task automatic test_reset();
    int nz;
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_hold: s_ready=%0b m_valid=%0b required 0 0", s_ready, m_valid);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %0b required 1", s_ready); end
    n_cmp++;
    if (m_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: m_valid=%0b frame_err=%0b required 0 0", m_valid, frame_err);
    end
    nz = 0;
    for (int i = 0; i < NV; i++) if (llr_out[i] !== '0) nz++;
    for (int i = 0; i < NE; i++) if (edge_msg[i] !== '0) nz++;
    n_cmp++;
    if (nz != 0) begin n_err++; $display("FAIL reset_outputs: %0d nonzero entries required 0", nz); end
  endtask

  task automatic test_nominal();
    int p0, f0;
    p0 = err_pulses; f0 = frames_seen;
    set_adj_mod();
    for (int v = 0; v < NV; v++) vals[v] = FP'(v - 20);
    m_ready = 1'b1;
    push_expected();
    send_frame(NV, NV - 1, 1'b0);
    tick();
    n_cmp++;
    if (m_valid !== 1'b0) begin n_err++; $display("FAIL nom_latency_t1: m_valid=%0b required 0", m_valid); end
    tick();
    n_cmp++;
    if (m_valid !== 1'b1) begin n_err++; $display("FAIL nom_latency_t2: m_valid=%0b required 1", m_valid); end
    n_cmp++;
    if (llr_out[7] !== -8'sd13) begin n_err++; $display("FAIL nom_llr7: got %0d required -13", llr_out[7]); end
    n_cmp++;
    if (edge_msg[51] !== -8'sd13) begin n_err++; $display("FAIL nom_edge51: got %0d required -13", edge_msg[51]); end
    n_cmp++;
    if (edge_msg[146] !== -8'sd6) begin n_err++; $display("FAIL nom_edge146: got %0d required -6", edge_msg[146]); end
    tick();
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_err++; $display("FAIL nom_after_hs: m_valid=%0b s_ready=%0b required 0 1", m_valid, s_ready);
    end
    wait_frames(f0 + 1);
    n_cmp++;
    if (err_pulses != p0) begin n_err++; $display("FAIL nom_no_err: pulses=%0d required 0", err_pulses - p0); end
  endtask

  task automatic test_backpressure();
    int f0;
    f0 = frames_seen;
    set_adj_mod();
    for (int v = 0; v < NV; v++) vals[v] = FP'(v - 20);
    m_ready = 1'b0;
    push_expected();
    send_frame(NV, NV - 1, 1'b1);
    n_cmp++;
    if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_map_s_ready: got %0b required 0", s_ready); end
    tick();
    tick();
    adj = '0;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cycle %0d: m_valid=%0b s_ready=%0b required 1 0", c, m_valid, s_ready);
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_after_hs: s_ready=%0b m_valid=%0b required 1 0", s_ready, m_valid);
    end
    set_adj_mod();
    wait_frames(f0 + 1);
  endtask

  task automatic test_early_last();
    int p0, f0, bad;
    p0 = err_pulses; f0 = frames_seen;
    set_adj_mod();
    for (int v = 0; v < NV; v++) vals[v] = FP'(7 * v - 120);
    send_frame(21, 20, 1'b0);
    n_cmp++;
    if (frame_err !== 1'b1) begin n_err++; $display("FAIL early_err_pulse: got %0b required 1", frame_err); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin if (m_valid !== 1'b0) bad++; tick(); end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL early_no_valid: %0d cycles m_valid=1 required 0", bad); end
    n_cmp++;
    if (err_pulses != p0 + 1) begin
      n_err++; $display("FAIL early_err_count: got %0d required 1", err_pulses - p0);
    end
    for (int v = 0; v < NV; v++) vals[v] = FP'(5 * v - 100);
    push_expected();
    send_frame(NV, NV - 1, 1'b0);
    wait_frames(f0 + 1);
    n_cmp++;
    if (err_pulses != p0 + 1) begin
      n_err++; $display("FAIL early_clean_frame_err: pulses=%0d required 1", err_pulses - p0);
    end
  endtask

  task automatic test_missing_last();
    int p0, f0;
    p0 = err_pulses; f0 = frames_seen;
    set_adj_mod();
    for (int v = 0; v < NV; v++) adj[v][5] = 1'b0;
    for (int v = 0; v < NV; v++) adj[v][6] = (v == 3) || (v == 9);
    for (int v = 0; v < NV; v++) vals[v] = FP'($urandom_range(0, 255));
    vals[0] = -8'sd128; vals[3] = 8'sd77; vals[6] = 8'sd33; vals[9] = -8'sd55;
    push_expected();
    send_frame(NV, -1, 1'b0);
    n_cmp++;
    if (frame_err !== 1'b1) begin n_err++; $display("FAIL miss_err_pulse: got %0b required 1", frame_err); end
    wait_frames(f0 + 1);
    n_cmp++;
    if (edge_msg[5] !== 8'sd0) begin n_err++; $display("FAIL miss_edge5: got %0d required 0", edge_msg[5]); end
    n_cmp++;
    if (edge_msg[6] !== 8'sd77) begin n_err++; $display("FAIL miss_edge6: got %0d required 77", edge_msg[6]); end
    n_cmp++;
    if (llr_out[0] !== -8'sd128) begin n_err++; $display("FAIL miss_llr0: got %0d required -128", llr_out[0]); end
    n_cmp++;
    if (err_pulses != p0 + 1) begin n_err++; $display("FAIL miss_err_count: got %0d required 1", err_pulses - p0); end
  endtask

  task automatic test_reset_midframe();
    int p0, f0, nz;
    p0 = err_pulses; f0 = frames_seen;
    set_adj_mod();
    for (int v = 0; v < NV; v++) vals[v] = FP'(-3 * v + 60);
    send_frame(30, -1, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    nz = 0;
    for (int i = 0; i < NV; i++) if (llr_out[i] !== '0) nz++;
    for (int i = 0; i < NE; i++) if (edge_msg[i] !== '0) nz++;
    n_cmp++;
    if (nz != 0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_state: nonzero=%0d s_ready=%0b m_valid=%0b required 0 0 0", nz, s_ready, m_valid);
    end
    rst = 1'b1;
    tick();
    for (int v = 0; v < NV; v++) vals[v] = FP'(11 * v - 128);
    push_expected();
    send_frame(NV, NV - 1, 1'b0);
    wait_frames(f0 + 1);
    n_cmp++;
    if (err_pulses != p0) begin n_err++; $display("FAIL rst_mid_no_err: pulses=%0d required 0", err_pulses - p0); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_midframe();
    n_cmp++;
    if (q_llr.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d frames never output, required 0", q_llr.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/in_layer_loader.md
Name: in_layer_loader

Overview:
- Serial-to-parallel front end of the neural min-sum decoder.
- Accepts channel LLRs one per cycle over a valid/ready stream and buffers a full codeword of N_V values.
- Presents the codeword in parallel as per-variable LLRs, the llr input the output layer consumes, and as initial per-edge messages scattered through the Tanner-graph adjacency matrix for the first decoding layer.
- Frame-level valid/ready handshake on the output side.

Parameters:
- N_V, 44, number of variable nodes.
- N_C, 12, number of check nodes (carried for interface uniformity, unused internally).
- E, 147, number of Tanner-graph edges.
- N_FP, 8, signed fixed-point LLR width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- adj_matrix  input  [0:N_V-1][0:E-1] x 1  variable-to-edge adjacency, static during operation.
- s_valid  input  1  input LLR word valid.
- s_ready  output  1  block can accept a word.
- s_llr  input  N_FP signed  channel LLR for the current variable index.
- s_last  input  1  marks the final word of a frame.
- llr_out  output  [0:N_V-1] x N_FP signed  buffered codeword LLRs.
- edge_msg  output  [0:E-1] x N_FP signed  initial edge messages.
- m_valid  output  1  llr_out/edge_msg hold a complete frame.
- m_ready  input  1  downstream accepts the frame.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (rst=0, asynchronous):
  - State LOAD, word index idx=0.
  - s_ready=0, m_valid=0, frame_err=0.
  - All llr_out and edge_msg entries 0.
  - First cycle after release: s_ready=1.
- FSM states: LOAD, MAP, HOLD.
- LOAD:
  - s_ready=1.
  - Beat = s_valid & s_ready. On a beat, the buffer at idx captures s_llr.
  - idx<N_V-1, s_last=0: idx++.
  - idx<N_V-1, s_last=1: frame discarded, frame_err pulses next cycle, idx->0, stay in LOAD. Buffer contents are don't-care until overwritten.
  - idx=N_V-1: frame complete, idx->0, go to MAP. If s_last=0 on this beat, frame_err also pulses, but the frame is kept.
- MAP (one cycle):
  - s_ready=0.
  - llr_out registers the buffer.
  - edge_msg[e] registers the buffer entry of the lowest v with adj_matrix[v][e]=1, or 0 if column e has no set bit.
  - Go to HOLD.
- HOLD:
  - m_valid=1, s_ready=0.
  - llr_out and edge_msg are held stable while m_valid=1 and m_ready=0.
  - On m_valid & m_ready: m_valid->0 next cycle, go to LOAD.
  - Outputs retain their last values after the handshake.
- Latency: last beat accepted at edge t gives m_valid=1 after edge t+2. The earliest next frame beat is one cycle after the m_ready handshake.
- m_ready is ignored outside HOLD. s_valid is ignored when s_ready=0, and no word is lost because the producer holds it.
- Arithmetic: pure routing, no arithmetic. Values are passed bit-exact; -2^(N_FP-1) is passed unchanged.
- adj_matrix is sampled only in MAP. Changing it at other times has no effect on the current frame.
- Reset asserted mid-frame or in HOLD:
  - Immediate return to reset values and partial frame dropped.
  - No frame_err pulse for a reset-aborted frame.
- frame_err is registered, exactly one cycle wide per violation, and independent of m_valid.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, release. Required: s_ready=1, m_valid=0, all outputs 0, frame_err=0 on the first cycle after release.
- Nominal frame:
  - Stimulus: adj_matrix[v][e]=1 iff v = e mod 44; stream s_llr=v-20 for v=0..43 back-to-back, s_last on v=43; m_ready=1.
  - Required: m_valid exactly 2 cycles after the last beat; llr_out[7]=-13; edge_msg[51]=-13; edge_msg[146]=-6; m_valid high for 1 cycle.
- Backpressure and throttling:
  - Stimulus: same frame with s_valid toggling 1/0; m_ready=0 for 10 cycles, then 1.
  - Required: s_ready=0 throughout MAP/HOLD; outputs stable for all 10 cycles; s_ready=1 one cycle after the handshake.
- Early s_last: assert s_last on word 20. Required: frame_err pulses once, m_valid stays 0, and the following 44-word frame is output correctly with no contamination.
- Missing s_last and edge cases:
  - Stimulus: 44-word frame with s_last=0; adj_matrix column 5 all zero; column 6 set for v=3 and v=9; s_llr[0]=-128.
  - Required: frame_err pulse and frame still output; edge_msg[5]=0; edge_msg[6]=s_llr[3]; llr_out[0]=-128.
- Reset mid-frame: pull rst low after 30 words, release, then send a full frame. Required: no frame_err; m_valid only after the new frame; outputs match the new frame.
